// File: rtl/redmule_tb_pkg.sv
// Shared types for the TCDM burst master traffic source.
//   tbm_state_e         : burst master FSM states
//   tbm_cfg_t           : latched burst configuration (fields sized for the widest legal instance)
//   TBM_MAX_OUTST_LIMIT : upper bound for the MAX_OUTST parameter
package redmule_tb_pkg;

  localparam int unsigned TBM_MAX_OUTST_LIMIT = 7;

  // Struct fields are sized for the largest supported instance; users truncate.
  localparam int unsigned TBM_ADDR_MAX_W = 64;
  localparam int unsigned TBM_DATA_MAX_W = 64;
  localparam int unsigned TBM_LEN_MAX_W  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } tbm_state_e;

  typedef struct packed {
    logic [TBM_ADDR_MAX_W-1:0] addr;
    logic [TBM_LEN_MAX_W-1:0]  len;
    logic [TBM_ADDR_MAX_W-1:0] stride;
    logic                      we;
    logic [TBM_DATA_MAX_W-1:0] seed;
  } tbm_cfg_t;

endpackage

// File: rtl/tcdm_outst_counter.sv
// Saturating up/down counter of granted-but-unanswered TCDM requests.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   inc_i         : a request was granted this cycle
//   dec_i         : a response arrived this cycle
//   cnt_o         : current count
//   full_o        : count equals MaxCnt (no further issue allowed)
//   underflow_o   : response arrived while nothing was outstanding
module tcdm_outst_counter #(
  parameter int unsigned MaxCnt = 2,
  parameter int unsigned CntW   = $clog2(MaxCnt + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            full_o,
  output logic            underflow_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_inc, do_dec;

  assign full_o      = (cnt_q == CntW'(MaxCnt));
  assign underflow_o = dec_i && (cnt_q == '0);
  assign cnt_o       = cnt_q;

  always_comb begin
    do_inc = inc_i && !full_o;
    do_dec = dec_i && (cnt_q != '0);
    cnt_d  = cnt_q;
    if (do_inc && !do_dec) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_dec && !do_inc) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tcdm_burst_master.sv
// Self-timed TCDM initiator: issues a programmable burst of word reads or writes on one
// req/gnt/r_valid port, folds read data into a checksum and counts granted transactions.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, cfg_*_i    : burst launch and configuration (sampled in IDLE)
//   busy_o, done_o      : status; done_o pulses one cycle at burst end
//   err_o               : sticky unexpected-response / start-while-busy flag
//   checksum_o          : running sum of read data for the current burst
//   rd_cnt_o, wr_cnt_o  : granted reads/writes since reset
//   tcdm_*              : TCDM request outputs and response inputs
module tcdm_burst_master
  import redmule_tb_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [AW-1:0]    cfg_stride_i,
  input  logic             cfg_we_i,
  input  logic [DW-1:0]    cfg_seed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [DW-1:0]    checksum_o,
  output logic [31:0]      rd_cnt_o,
  output logic [31:0]      wr_cnt_o,
  output logic             tcdm_req_o,
  output logic [AW-1:0]    tcdm_add_o,
  output logic             tcdm_wen_o,
  output logic [DW/8-1:0]  tcdm_be_o,
  output logic [DW-1:0]    tcdm_data_o,
  input  logic             tcdm_gnt_i,
  input  logic [DW-1:0]    tcdm_r_data_i,
  input  logic             tcdm_r_valid_i
);

  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
  localparam int unsigned BeW  = DW / 8;

  if (!(DW == 32 || DW == 64)) begin : gen_dw_check
    $error("tcdm_burst_master: DW must be 32 or 64");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > TBM_MAX_OUTST_LIMIT) begin : gen_outst_check
    $error("tcdm_burst_master: MAX_OUTST out of range");
  end

  tbm_state_e       state_q;
  // addr and seed fields advance per grant: they hold the current word's address and data.
  tbm_cfg_t         cfg_q, cfg_in;
  logic [LEN_W-1:0] idx_q;
  logic             done_q, err_q;
  logic [DW-1:0]    checksum_q;
  logic [31:0]      rd_cnt_q, wr_cnt_q;
  // Post-reset window during which stray responses from an aborted burst are dropped silently.
  logic [CntW-1:0]  ign_q;

  logic [CntW-1:0]  outst;
  logic             outst_full, outst_underflow;
  logic             issuing, req, grant, last_grant, rsp_ok, drain_empty;
  logic             unused_cfg;

  tcdm_outst_counter #(
    .MaxCnt (MAX_OUTST),
    .CntW   (CntW)
  ) u_outst (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (grant),
    .dec_i       (tcdm_r_valid_i),
    .cnt_o       (outst),
    .full_o      (outst_full),
    .underflow_o (outst_underflow)
  );

  always_comb begin
    cfg_in        = '0;
    cfg_in.addr   = TBM_ADDR_MAX_W'(cfg_addr_i);
    cfg_in.len    = TBM_LEN_MAX_W'(cfg_len_i);
    cfg_in.stride = TBM_ADDR_MAX_W'(cfg_stride_i);
    cfg_in.we     = cfg_we_i;
    cfg_in.seed   = TBM_DATA_MAX_W'(cfg_seed_i);
  end

  // Issue depends only on registered state, never on r_valid or gnt.
  assign issuing     = (state_q == StIssue);
  assign req         = issuing && !outst_full;
  assign grant       = req && tcdm_gnt_i;
  assign last_grant  = grant && ((idx_q + LEN_W'(1)) == cfg_q.len[LEN_W-1:0]);
  assign rsp_ok      = tcdm_r_valid_i && !outst_underflow;
  // No grants happen in DRAIN, so only the response can change the count.
  assign drain_empty = (outst == '0) || ((outst == CntW'(1)) && rsp_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cfg_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      checksum_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      ign_q      <= CntW'(MAX_OUTST);
    end else begin
      done_q <= 1'b0;
      if (ign_q != '0) begin
        ign_q <= ign_q - CntW'(1);
      end
      if ((outst_underflow && (ign_q == '0)) || (start_i && (state_q != StIdle))) begin
        err_q <= 1'b1;
      end
      if (grant) begin
        idx_q      <= idx_q + LEN_W'(1);
        cfg_q.addr <= cfg_q.addr + cfg_q.stride;
        cfg_q.seed <= cfg_q.seed + TBM_DATA_MAX_W'(1);
        if (cfg_q.we) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end
      if (rsp_ok && !cfg_q.we) begin
        checksum_q <= checksum_q + tcdm_r_data_i;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            cfg_q      <= cfg_in;
            idx_q      <= '0;
            checksum_q <= '0;
            if (cfg_len_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (last_grant) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_empty) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign checksum_o  = checksum_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

  assign tcdm_req_o  = req;
  assign tcdm_add_o  = issuing ? cfg_q.addr[AW-1:0] : '0;
  assign tcdm_wen_o  = issuing && !cfg_q.we;
  assign tcdm_be_o   = {BeW{issuing}};
  assign tcdm_data_o = (issuing && cfg_q.we) ? cfg_q.seed[DW-1:0] : '0;

  // Upper bits of the wide config fields are never used at this instance's widths.
  assign unused_cfg = ^cfg_q;

endmodule

// File: tb/tb_tcdm_burst_master.sv
module tb_tcdm_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned MaxOutst = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [AW-1:0]    cfg_addr_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic [AW-1:0]    cfg_stride_i;
  logic             cfg_we_i;
  logic [DW-1:0]    cfg_seed_i;
  logic             busy_o, done_o, err_o;
  logic [DW-1:0]    checksum_o;
  logic [31:0]      rd_cnt_o, wr_cnt_o;
  logic             tcdm_req_o, tcdm_wen_o;
  logic [AW-1:0]    tcdm_add_o;
  logic [DW/8-1:0]  tcdm_be_o;
  logic [DW-1:0]    tcdm_data_o;
  logic             tcdm_gnt_i;
  logic [DW-1:0]    tcdm_r_data_i;
  logic             tcdm_r_valid_i;

  tcdm_burst_master #(
    .DW        (DW),
    .AW        (AW),
    .LEN_W     (LEN_W),
    .MAX_OUTST (MaxOutst)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_len_i      (cfg_len_i),
    .cfg_stride_i   (cfg_stride_i),
    .cfg_we_i       (cfg_we_i),
    .cfg_seed_i     (cfg_seed_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .checksum_o     (checksum_o),
    .rd_cnt_o       (rd_cnt_o),
    .wr_cnt_o       (wr_cnt_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_req_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_req_t    exp_q[$];
  logic [31:0] mem [logic [31:0]];

  // Responder state
  bit          gnt_rand   = 0;
  bit          inject_rv  = 0;
  bit          flush_req  = 0;
  bit          pend       = 0;
  logic [31:0] pend_data  = '0;
  int          outst_m    = 0;
  int          grant_cnt  = 0;
  int          req_seen   = 0;
  bit          stalled    = 0;
  logic [31:0] st_addr, st_data;
  logic        st_wen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] model_cks(input logic [31:0] base, input int len,
                                            input logic [31:0] stride);
    logic [31:0] s = '0;
    for (int k = 0; k < len; k++) s += fill(base + stride * k);
    return s;
  endfunction

  // TCDM responder + request monitor: drives gnt and a latency-1 r_valid on the falling edge.
  initial begin
    tcdm_gnt_i     = 1'b0;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (flush_req) begin
        outst_m   = 0;
        exp_q.delete();
        flush_req = 0;
      end
      tcdm_r_valid_i = pend || inject_rv;
      tcdm_r_data_i  = pend ? pend_data : 32'hdead_beef;
      if (pend && outst_m > 0) outst_m--;
      pend      = 0;
      inject_rv = 0;
      if (stalled && !rst_i) begin
        check("req_held", tcdm_req_o, 1'b1);
        check("addr_stable", tcdm_add_o, st_addr);
        check("data_stable", tcdm_data_o, st_data);
        check("wen_stable", tcdm_wen_o, st_wen);
      end
      stalled    = 0;
      tcdm_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tcdm_req_o) req_seen++;
      if (tcdm_req_o && !tcdm_gnt_i && !rst_i) begin
        stalled = 1;
        st_addr = tcdm_add_o;
        st_data = tcdm_data_o;
        st_wen  = tcdm_wen_o;
      end
      if (tcdm_req_o && tcdm_gnt_i) begin
        grant_cnt++;
        pend      = 1;
        pend_data = '0;
        if (!rst_i) begin
          exp_req_t e;
          outst_m++;
          check("outst_le_max", outst_m <= MaxOutst, 1'b1);
          check("be_all_ones", tcdm_be_o, 4'hf);
          check("sb_avail", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("req_addr", tcdm_add_o, e.addr);
            check("req_wen", tcdm_wen_o, e.wen);
            check("req_data", tcdm_data_o, e.data);
          end
          if (!tcdm_wen_o) mem[tcdm_add_o] = tcdm_data_o;
          else pend_data = mem_rd(tcdm_add_o);
        end
      end
    end
  end

  // Launch a burst, queue the expected requests and wait (bounded) for done_o.
  task automatic run_burst(input logic [31:0] base, input int len, input logic [31:0] stride,
                           input logic we, input logic [31:0] seed, output int lat);
    @(negedge clk_i);
    for (int k = 0; k < len; k++) begin
      exp_req_t e;
      e.wen  = ~we;
      e.addr = base + stride * k;
      e.data = we ? seed + k : 32'h0;
      exp_q.push_back(e);
    end
    cfg_addr_i   = base;
    cfg_len_i    = LEN_W'(len);
    cfg_stride_i = stride;
    cfg_we_i     = we;
    cfg_seed_i   = seed;
    start_i      = 1'b1;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        lat = i;
        break;
      end
    end
    check("done_seen", lat != 0, 1'b1);
    @(negedge clk_i);
    check("done_one_cycle", done_o, 1'b0);
    check("idle_after_done", busy_o, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    rst_i = 1'b1;
    flush_req = 1;
    repeat (cycles) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int snap;
    rst_i = 1'b1;
    start_i = 1'b0;
    cfg_addr_i = '0; cfg_len_i = '0; cfg_stride_i = '0; cfg_we_i = 1'b0; cfg_seed_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cks", checksum_o, 0);
    check("rst_rd", rd_cnt_o, 0);
    check("rst_wr", wr_cnt_o, 0);
    check("rst_req", tcdm_req_o, 0);
    check("rst_add", tcdm_add_o, 0);
    check("rst_be", tcdm_be_o, 0);
    check("rst_data", tcdm_data_o, 0);
    check("rst_wen", tcdm_wen_o, 0);
    repeat (3) @(negedge clk_i);

    // Write burst
    run_burst(32'h1c01_0000, 4, 32'd4, 1'b1, 32'hA0, lat);
    check("wr_lat", lat, 6);
    check("wr_cnt", wr_cnt_o, 4);
    check("wr_err", err_o, 0);
    for (int k = 0; k < 4; k++) check("wr_mem", mem_rd(32'h1c01_0000 + 4 * k), 32'hA0 + k);

    // Read-back
    run_burst(32'h1c01_0000, 4, 32'd4, 1'b0, 32'h0, lat);
    check("rd_lat", lat, 6);
    check("rd_cks", checksum_o, 32'h286);
    check("rd_cnt", rd_cnt_o, 4);
    check("rd_wr_cnt_kept", wr_cnt_o, 4);

    // Random grant stalls
    do_reset(2);
    check("rst2_rd", rd_cnt_o, 0);
    gnt_rand = 1;
    run_burst(32'h1c02_0000, 16, 32'd8, 1'b0, 32'h0, lat);
    gnt_rand = 0;
    check("stall_rd_cnt", rd_cnt_o, 16);
    check("stall_cks", checksum_o, model_cks(32'h1c02_0000, 16, 32'd8));
    check("stall_err", err_o, 0);
    check("stall_sb_empty", exp_q.size(), 0);

    // Zero-length burst
    snap = req_seen;
    run_burst(32'h1c05_0000, 0, 32'd4, 1'b0, 32'h0, lat);
    check("len0_lat_le2", (lat >= 1) && (lat <= 2), 1'b1);
    check("len0_no_req", req_seen, snap);
    check("len0_rd", rd_cnt_o, 16);
    check("len0_wr", wr_cnt_o, 0);
    check("len0_cks", checksum_o, 0);

    // Spurious r_valid while idle
    inject_rv = 1;
    repeat (2) @(negedge clk_i);
    check("spur_err", err_o, 1);
    repeat (5) @(negedge clk_i);
    check("spur_err_held", err_o, 1);
    do_reset(1);
    check("spur_err_cleared", err_o, 0);
    repeat (2) @(negedge clk_i);

    // Reset after three grants of eight
    @(negedge clk_i);
    for (int k = 0; k < 8; k++) begin
      exp_req_t e;
      e.wen = 1'b1; e.addr = 32'h1c03_0000 + 4 * k; e.data = '0;
      exp_q.push_back(e);
    end
    cfg_addr_i = 32'h1c03_0000; cfg_len_i = 16'd8; cfg_stride_i = 32'd4; cfg_we_i = 1'b0;
    snap = grant_cnt;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 50 && grant_cnt < snap + 3; i++) @(negedge clk_i);
    check("mid_grants_reached", grant_cnt >= snap + 3, 1'b1);
    rst_i = 1'b1;
    flush_req = 1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_req", tcdm_req_o, 0);
    check("mid_busy", busy_o, 0);
    check("mid_rd", rd_cnt_o, 0);
    repeat (4) @(negedge clk_i);
    check("mid_no_err", err_o, 0);
    run_burst(32'h1c04_0000, 8, 32'd4, 1'b0, 32'h0, lat);
    check("post_lat", lat, 10);
    check("post_rd", rd_cnt_o, 8);
    check("post_cks", checksum_o, model_cks(32'h1c04_0000, 8, 32'd4));
    check("post_err", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
